// File: rtl/alu_seq_exec.sv
// Sequential ALU execute stage: single-cycle logic/arithmetic ops plus a serial
// one-bit-per-cycle SLL, with registered result and a start/done handshake.
module alu_seq_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             invalid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             invalid_q, invalid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sh_next_s;

    // Signed less-than by sign bits first, so it never depends on a-b overflowing.
    function automatic logic slt_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic lt;
        if (x[WIDTH-1] != y[WIDTH-1]) begin
            lt = x[WIDTH-1];
        end else begin
            lt = (x[WIDTH-2:0] < y[WIDTH-2:0]);
        end
        return lt;
    endfunction

    assign sh_next_s = {sh_q[WIDTH-2:0], 1'b0};

    // Next-state and completion logic for both the single-cycle and serial paths.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        invalid_d = invalid_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d    = 1'b1;
                    invalid_d = 1'b0;
                    case (alu_ctrl)
                        4'b0000: result_d = a & b;
                        4'b0001: result_d = a | b;
                        4'b0010: result_d = a + b;
                        4'b0110: result_d = a - b;
                        4'b0111: result_d = {{(WIDTH-1){1'b0}}, slt_f(a, b)};
                        4'b1110: begin
                            if (shamt == CNT_ZERO) begin
                                result_d = b;
                            end else begin
                                // Serial shift: the result stays untouched until the last step.
                                done_d    = 1'b0;
                                invalid_d = invalid_q;
                                sh_d      = b;
                                cnt_d     = shamt;
                                state_d   = S_SHIFT;
                            end
                        end
                        default: begin
                            result_d  = W_ZERO;
                            invalid_d = 1'b1;
                        end
                    endcase
                    if (done_d) begin
                        zero_d = (result_d == W_ZERO);
                    end else begin
                        zero_d = zero_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                sh_d  = sh_next_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d  = sh_next_s;
                    zero_d    = (sh_next_s == W_ZERO);
                    invalid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sh_q      <= W_ZERO;
            cnt_q     <= CNT_ZERO;
            result_q  <= W_ZERO;
            zero_q    <= 1'b1;
            invalid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            invalid_q <= invalid_d;
            done_q    <= done_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign invalid = invalid_q;
    assign done    = done_q;
    assign busy    = (state_q == S_SHIFT);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus random ops compared
// against an arithmetic reference model and a latency model.
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        invalid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
        .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero),
        .invalid(invalid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {invalid, result} from the op definitions.
    function automatic logic [32:0] model(input logic [3:0] code, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] s);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if ($isunknown(code)) return {1'b1, 32'd0};
        case (code)
            4'd0:    return {1'b0, x & y};
            4'd1:    return {1'b0, x | y};
            4'd2:    return {1'b0, x + y};
            4'd6:    return {1'b0, x - y};
            4'd7:    return {1'b0, (sx < sy) ? 32'd1 : 32'd0};
            4'd14:   return {1'b0, y << s};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at the current cycle and follow it to its done cycle.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] sh, input bit poke);
        logic [32:0] exp;
        int lat;
        exp = model(code, av, bv, sh);
        lat = (code === 4'd14 && sh != 5'd0) ? int'(sh) + 1 : 1;
        start = 1'b1; alu_ctrl = code; a = av; b = bv; shamt = sh;
        step();
        start = 1'b0; alu_ctrl = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
                chk({tag, ".nodone"}, {31'd0, done}, 32'd0);
            end else begin
                chk({tag, ".done"}, {31'd0, done}, 32'd1);
                chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
                chk({tag, ".result"}, result, exp[31:0]);
                chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp[31:0] == 32'd0});
                chk({tag, ".invalid"}, {31'd0, invalid}, {31'd0, exp[32]});
            end
            if (poke && k == 2) start = 1'b1;
            if (poke && k == 3) start = 1'b0;
            if (k < lat) step();
        end
    endtask

    initial begin
        logic [3:0]  codes [7];
        logic [31:0] held;
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd14, 4'd14};
        reset = 1'b1; start = 1'b0; alu_ctrl = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
        step(); step();
        reset = 1'b0;
        chk("rst.result", result, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        chk("rst.invalid", {31'd0, invalid}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        run_op("sub", 4'b0110, 32'd5, 32'd7, 5'd3, 1'b0);
        run_op("slt_pos_neg", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 1'b0);
        run_op("slt_neg_pos", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 1'b0);
        run_op("sll4", 4'b1110, 32'h0, 32'h0000_0003, 5'd4, 1'b1);
        chk("sll4.result_c", result, 32'h0000_0030);
        held = result;
        step();
        chk("poke.ignored", {31'd0, done}, 32'd0);
        chk("poke.notbusy", {31'd0, busy}, 32'd0);
        chk("poke.hold", result, held);
        run_op("sll0", 4'b1110, 32'h0, 32'h1234_ABCD, 5'd0, 1'b0);
        run_op("sll31", 4'b1110, 32'h0, 32'h0000_0001, 5'd31, 1'b0);
        chk("sll31.result_c", result, 32'h8000_0000);
        run_op("sll_to_zero", 4'b1110, 32'h0, 32'h8000_0000, 5'd1, 1'b0);

        // Back-to-back AND then OR.
        start = 1'b1; alu_ctrl = 4'b0000; a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
        step();
        alu_ctrl = 4'b0001; a = 32'hF0F0_F000; b = 32'h0000_0F0F;
        chk("b2b.done1", {31'd0, done}, 32'd1);
        chk("b2b.and", result, 32'h00F0_00F0);
        step();
        start = 1'b0;
        chk("b2b.done2", {31'd0, done}, 32'd1);
        chk("b2b.or", result, 32'hF0F0_FF0F);
        step();
        chk("hold.done", {31'd0, done}, 32'd0);
        chk("hold.result", result, 32'hF0F0_FF0F);

        run_op("invalid1010", 4'b1010, 32'h1234_5678, 32'h1234_5678, 5'd0, 1'b0);
        run_op("invalid_x", 4'bxxxx, 32'h1, 32'h2, 5'd0, 1'b0);
        run_op("add_clears", 4'b0010, 32'd40, 32'd2, 5'd0, 1'b0);

        // Reset in the middle of a long shift.
        start = 1'b1; alu_ctrl = 4'b1110; b = 32'hFFFF_FFFF; shamt = 5'd20;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("midrst.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.result", result, 32'd0);
        chk("midrst.zero", {31'd0, zero}, 32'd1);
        chk("midrst.invalid", {31'd0, invalid}, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("midrst.nodone", {31'd0, done}, 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            c = (i % 8 == 7) ? 4'($urandom) : codes[$urandom_range(0, 6)];
            run_op("rand", c, $urandom, $urandom, 5'($urandom), 1'($urandom));
        end
        step();
        chk("final.done", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential execute stage that consumes the 4-bit ALU control code produced by the ALU control decoder. It executes the selected operation on two 32-bit operands and returns a registered result with a start/done handshake. Logical and arithmetic ops complete in one cycle. Shift-left-logical (code 1110, funct 000000) is performed serially, one bit per cycle, so the datapath carries no 32-bit barrel shifter.

## Interface

Parameters:
- WIDTH, 32, operand and result width; all behaviour below is given for 32.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on rising edge; accepted only when busy=0.
- alu_ctrl  in  4  operation code from the ALU control decoder.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate); the shift source for SLL.
- shamt  in  SHW  shift amount for SLL; ignored for other codes.
- result  out  WIDTH  registered result; holds until the next completion.
- zero  out  1  registered; 1 when the registered result equals 0.
- invalid  out  1  registered; 1 when the last completed op had an unsupported code.
- busy  out  1  high while a serial shift is in progress.
- done  out  1  one-cycle pulse when result, zero and invalid update.

## Operation

Op codes:
- 0000 AND.
- 0001 OR.
- 0010 ADD, modulo 2^32, no overflow trap.
- 0110 SUB, a−b modulo 2^32.
- 0111 SLT, signed: result = 1 if signed a < signed b, else 0. The comparison is correct across sign boundaries and does not rely on the sign of a−b.
- 1110 SLL: result = b << shamt, with zero fill.
- Any other code, including X/unknown: result = 0, invalid = 1, with single-cycle completion.

Operands, code and shamt are captured at the accept edge. Later input changes have no effect on an op in flight.

States:
- IDLE:
  - start=1 accepts the request.
  - A non-shift op, or SLL with shamt=0, writes result, zero and invalid at the accept edge, pulses done and stays in IDLE.
  - SLL with shamt≥1 loads the shift register with b and the counter with shamt, then goes to SHIFT.
- SHIFT:
  - Each edge shifts the register left by 1 and decrements the counter.
  - On the edge where the counter goes 1→0, the shifted value is written to result, zero and invalid (invalid=0), done pulses and the block returns to IDLE.
  - start is ignored in SHIFT; it is not queued.

Status outputs:
- busy = 1 exactly while in SHIFT.
- done is never high in two consecutive cycles from one request.
- result, zero and invalid change only on a done cycle or on reset.

## Timing

Latency is counted from the cycle in which start is sampled high, cycle c:
- Non-shift ops and SLL with shamt=0: done=1 and the new result in cycle c+1.
- SLL with shamt=n≥1: busy=1 in cycles c+1..c+n; done=1 and the new result in cycle c+n+1, where busy=0.

Throughput and overlap:
- Back-to-back starts are accepted every cycle for single-cycle ops.
- A start asserted in a done cycle is accepted, because the block is in IDLE.

Reset:
- Reset has priority over start and over an in-flight shift.
- Reset mid-shift aborts the shift with no done pulse.
- Reset values on the cycle after reset is sampled: result=0, zero=1, invalid=0, busy=0, done=0, state IDLE, counter 0.

Boundaries:
- shamt=31 gives latency 32 and result = b[0]<<31.
- An SLL result of 0, for example b=0x8000_0000 with shamt=1, sets zero=1.

## Test plan

- Reset then ADD: a=0xFFFF_FFFF, b=0x0000_0001, code 0010 → cycle c+1: done=1, result=0x0000_0000, zero=1, invalid=0. Reset-mid-run check: hold reset during a shamt=20 SLL at cycle c+5 → no done, busy=0, result=0, zero=1.
- SUB and SLT sign boundary:
  - SUB a=5, b=7 → result=0xFFFF_FFFE.
  - SLT a=0x7FFF_FFFF, b=0x8000_0000 → result=0.
  - SLT a=0x8000_0000, b=0x7FFF_FFFF → result=1.
  - All three with 1-cycle latency.
- SLL serial: b=0x0000_0003, shamt=4 → busy high in cycles c+1..c+4, done in c+5, result=0x0000_0030. Second start pulsed at c+2 is ignored. shamt=0 → done in c+1, result=b.
- SLL extreme: b=0x0000_0001, shamt=31 → done in c+32, result=0x8000_0000, zero=0. b=0x8000_0000, shamt=1 → result=0, zero=1.
- Back-to-back and hold:
  - AND (0xF0F0_F0F0 & 0x0FF0_0FF0 = 0x00F0_00F0) then OR (0xF0F0_F000 | 0x0000_0F0F = 0xF0F0_FF0F) on consecutive cycles → done in two consecutive cycles with those results.
  - Result holds after done falls.
- Invalid code 1010 with a=b=0x1234_5678 → cycle c+1: result=0, zero=1, invalid=1. A following valid ADD clears invalid to 0.
